// File: rtl/fp32_classify_arb.sv
// Two-requester round-robin arbiter feeding a single-entry FP32 classifier result register.
// Counts signaling-NaN results in a saturating, synchronously clearable counter.
module fp32_classify_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [31:0]      out_data,
  output logic [9:0]       out_class,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] snan_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [9:0] classify(input logic [31:0] d);
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic [9:0]  c;
    sign = d[31];
    expo = d[30:23];
    mant = d[22:0];
    c    = '0;
    if (expo == 8'hFF && mant != '0) begin
      if (mant[22]) c[1] = 1'b1;
      else          c[0] = 1'b1;
    end else if (expo == 8'hFF) begin
      if (sign) c[2] = 1'b1;
      else      c[9] = 1'b1;
    end else if (expo == 8'h00 && mant == '0) begin
      if (sign) c[5] = 1'b1;
      else      c[6] = 1'b1;
    end else if (expo == 8'h00) begin
      if (sign) c[4] = 1'b1;
      else      c[7] = 1'b1;
    end else begin
      if (sign) c[3] = 1'b1;
      else      c[8] = 1'b1;
    end
    return c;
  endfunction

  logic        rr;
  logic        load_ok;
  logic        grant0;
  logic        grant1;
  logic        load;
  logic [31:0] sel_data;
  logic [9:0]  sel_class;

  assign load_ok = !out_valid || out_ready;
  // rr names the requester that wins when both are offering
  assign grant0  = req0_valid && (!req1_valid || !rr);
  assign grant1  = req1_valid && (!req0_valid || rr);

  assign req0_ready = !rst && load_ok && grant0;
  assign req1_ready = !rst && load_ok && grant1;
  assign load       = req0_ready || req1_ready;

  assign sel_data  = grant1 ? req1_data : req0_data;
  assign sel_class = classify(sel_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
      rr        <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_id    <= grant1;
      out_data  <= sel_data;
      out_class <= sel_class;
      rr        <= !grant1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle sNaN load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snan_cnt <= '0;
    end else if (cnt_clr) begin
      snan_cnt <= '0;
    end else if (load && sel_class[0] && snan_cnt != CNT_MAX) begin
      snan_cnt <= snan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_classify_arb.sv
// Randomized and directed checks of fp32_classify_arb against a cycle-level behavioural model.
// Built with a 2-bit counter so saturation is reached quickly.
module tb_fp32_classify_arb;

  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, out_ready, cnt_clr;
  logic [31:0]   req0_data, req1_data;
  logic          req0_ready, req1_ready, out_valid, out_id;
  logic [31:0]   out_data;
  logic [9:0]    out_class;
  logic [CW-1:0] snan_cnt;

  int total = 0;
  int bad   = 0;

  bit          m_valid;
  bit          m_id;
  logic [31:0] m_data;
  logic [9:0]  m_class;
  int          m_cnt;
  int          m_rr;

  fp32_classify_arb #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_data(out_data), .out_class(out_class),
    .cnt_clr(cnt_clr), .snan_cnt(snan_cnt)
  );

  always #5 clk = ~clk;

  // Class index from the IEEE field values
  function automatic int cls_idx(input logic [31:0] d);
    int sign = int'(d >> 31);
    int e    = int'((d >> 23) & 32'hFF);
    int m    = int'(d & 32'h7FFFFF);
    if (e == 255 && m != 0) return (m >= 32'h400000) ? 1 : 0;
    if (e == 255)           return sign ? 2 : 9;
    if (e == 0 && m == 0)   return sign ? 5 : 6;
    if (e == 0)             return sign ? 4 : 7;
    return sign ? 3 : 8;
  endfunction

  function automatic int grant();
    if (req0_valid && req1_valid) return m_rr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_rdy(input int w);
    return !rst && (!m_valid || out_ready) && grant() == w;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] s = 32'($urandom_range(0, 1)) << 31;
    case ($urandom_range(0, 5))
      0: return s | 32'h7F800000 | 32'($urandom_range(1, 32'h3FFFFF));
      1: return s | 32'h7FC00000 | 32'($urandom_range(0, 32'h3FFFFF));
      2: return s | 32'h7F800000;
      3: return s;
      4: return s | 32'($urandom_range(1, 32'h7FFFFF));
      default: return s | (32'($urandom_range(1, 254)) << 23) | 32'($urandom_range(0, 32'h7FFFFF));
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_class = '0; m_cnt = 0; m_rr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      int g = grant();
      bit lok = !m_valid || out_ready;
      if (lok && g >= 0) begin
        int c;
        m_data  = (g == 1) ? req1_data : req0_data;
        c       = cls_idx(m_data);
        m_id    = (g == 1);
        m_class = 10'(1 << c);
        m_valid = 1;
        m_rr    = 1 - g;
        if (c == 0 && m_cnt < CMAX) m_cnt++;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (cnt_clr) m_cnt = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; out_ready = 1; cnt_clr = 0;
    req0_data = 32'h3F800000; req1_data = 32'h7F800001;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
    total++; if (out_class !== 10'h0 || out_data !== 32'h0 || out_id !== 1'b0) begin
      bad++; $display("FAIL rst_regs got=%0h/%0h/%0h exp=0/0/0", out_class, out_data, out_id); end
    total++; if (snan_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", snan_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL rst_hold got=%0b%0b%0b exp=000", req0_ready, req1_ready, out_valid); end
    end
    @(negedge clk); rst = 0; #1;
  endtask

  task automatic test_alternate();
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    req0_data = 32'h3F800000; req1_data = 32'hFF800000;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        bad++; $display("FAIL alt_ready got=%0b%0b exp_id=%0d", req0_ready, req1_ready, i % 2); end
      tick();
      total++; if (out_valid !== 1'b1 || out_id !== 1'(i % 2)) begin
        bad++; $display("FAIL alt_id got=%0h exp=%0h", out_id, i % 2); end
      total++; if (out_class !== ((i % 2) ? 10'h004 : 10'h100)) begin
        bad++; $display("FAIL alt_class got=%0h exp=%0h", out_class, (i % 2) ? 10'h004 : 10'h100); end
    end
  endtask

  task automatic test_snan();
    req1_valid = 0; req0_valid = 1; req0_data = 32'h7F800001; out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (out_class !== 10'h001 || snan_cnt !== CW'(i)) begin
        bad++; $display("FAIL snan got=%0h cnt=%0d exp=001 cnt=%0d", out_class, snan_cnt, i); end
    end
    req0_data = 32'h7FC00000;
    tick();
    total++; if (out_class !== 10'h002 || snan_cnt !== CW'(3)) begin
      bad++; $display("FAIL qnan got=%0h cnt=%0d exp=002 cnt=3", out_class, snan_cnt); end
    req0_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    req0_valid = 1; req0_data = 32'hFF800123; cnt_clr = 1;
    tick();
    total++; if (snan_cnt !== '0) begin bad++; $display("FAIL clr_first got=%0d exp=0", snan_cnt); end
    cnt_clr = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (snan_cnt !== CW'((i > 3) ? 3 : i)) begin
        bad++; $display("FAIL sat got=%0d exp=%0d", snan_cnt, (i > 3) ? 3 : i); end
    end
    cnt_clr = 1;
    tick();
    total++; if (snan_cnt !== '0 || out_class !== 10'h001) begin
      bad++; $display("FAIL clr_wins got=%0d/%0h exp=0/001", snan_cnt, out_class); end
    cnt_clr = 0;
  endtask

  task automatic test_stall();
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    tick();
    req0_valid = 1; req0_data = 32'h80000000; out_ready = 0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL stall_load got=%0b exp=1", req0_ready); end
    tick();
    req1_valid = 1; req0_data = 32'h3F800000; req1_data = 32'h7F800001;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL stall_ready got=%0b%0b exp=00", req0_ready, req1_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_class !== 10'h020 || out_data !== 32'h80000000) begin
        bad++; $display("FAIL stall_hold got=%0b/%0h/%0h exp=1/020/80000000", out_valid, out_class, out_data); end
    end
    out_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL stall_resume got=%0b%0b exp=01", req0_ready, req1_ready); end
    tick();
    total++; if (out_id !== 1'b1 || out_data !== 32'h7F800001) begin
      bad++; $display("FAIL stall_next got=%0h/%0h exp=1/7f800001", out_id, out_data); end
  endtask

  task automatic test_classes();
    logic [31:0] ops [3] = '{32'h00000001, 32'h80400000, 32'h00000000};
    logic [9:0]  exp [3] = '{10'h080, 10'h010, 10'h040};
    req1_valid = 0; req0_valid = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req0_data = ops[i];
      tick();
      total++; if (out_class !== exp[i] || out_data !== ops[i]) begin
        bad++; $display("FAIL class%0d got=%0h exp=%0h", i, out_class, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req1_valid = 0; req0_data = 32'h7F800002; out_ready = 0;
    tick();
    total++; if (out_valid !== 1'b1 || snan_cnt !== CW'(m_cnt) || m_cnt == 0) begin
      bad++; $display("FAIL pre_rst got=%0b/%0d exp=1/%0d", out_valid, snan_cnt, m_cnt); end
    #2; rst = 1; model_reset(); #1;
    total++; if (out_valid !== 1'b0 || snan_cnt !== '0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst got=%0b/%0d/%0b exp=0/0/0", out_valid, snan_cnt, req0_ready); end
    @(negedge clk); rst = 0; req1_valid = 1; req1_data = 32'h00000000; out_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL post_rst_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    tick();
    total++; if (out_id !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL post_rst_id got=%0h exp=0", out_id); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data  = pick();
      req1_data  = pick();
      out_ready  = ($urandom_range(0, 3) != 0);
      cnt_clr    = ($urandom_range(0, 19) == 0);
      #1;
      total++; if (req0_ready !== exp_rdy(0) || req1_ready !== exp_rdy(1)) begin
        bad++; $display("FAIL rnd_ready got=%0b%0b exp=%0b%0b", req0_ready, req1_ready, exp_rdy(0), exp_rdy(1)); end
      tick();
      total++; if (out_valid !== m_valid || snan_cnt !== CW'(m_cnt)) begin
        bad++; $display("FAIL rnd_state got=%0b/%0d exp=%0b/%0d", out_valid, snan_cnt, m_valid, m_cnt); end
      if (m_valid) begin
        total++; if (out_id !== m_id || out_data !== m_data || out_class !== m_class || $countones(out_class) != 1) begin
          bad++; $display("FAIL rnd_out got=%0h/%0h/%0h exp=%0h/%0h/%0h", out_id, out_data, out_class, m_id, m_data, m_class); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_snan();
    test_saturate();
    test_stall();
    test_classes();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
